// File: rtl/uart_axi_master_bridge_if.sv
// AXI4-lite master/slave bundle for the UART bridge.
// master: the bridge; slave: the attached AXI target.
interface uart_axi_master_bridge_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid,
    output arready, rvalid, rdata
  );
endinterface

// File: rtl/uart_axi_master_bridge.sv
// UART byte-frame to AXI4-lite master bridge.
// Ports: clk/resetn, rx byte strobe, tx valid/ready, busy, axi master.
module uart_axi_master_bridge #(
  parameter logic [31:0] RX_TIMEOUT = 32'd100000,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  uart_axi_master_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WR,
    WRESP,
    RD,
    RRESP,
    TX
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        aw_q, aw_d;
  logic        w_q, w_d;
  logic        ar_q, ar_d;
  logic [31:0] rep_q, rep_d;
  logic [2:0]  rep_n_q, rep_n_d;

  logic idle_last;
  logic aw_fin;
  logic w_fin;

  assign idle_last = (idle_q == RX_TIMEOUT - 32'd1);
  assign aw_fin    = !aw_q || axi.awready;
  assign w_fin     = !w_q || axi.wready;

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    addr_d  = addr_q;
    data_d  = data_q;
    aw_d    = aw_q;
    w_d     = w_q;
    ar_d    = ar_q;
    rep_d   = rep_q;
    rep_n_d = rep_n_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            is_wr_d = (rx_data == 8'h57);
            cnt_d   = 2'd0;
            idle_d  = 32'd0;
            state_d = ADDR;
          end else begin
            rep_d   = {8'h3F, 24'h0};
            rep_n_d = 3'd1;
            state_d = TX;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          idle_d = 32'd0;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = DATA;
            end else begin
              state_d = RD;
              ar_d    = 1'b1;
            end
          end
        end else if (idle_last) begin
          idle_d  = 32'd0;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          data_d = {data_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          idle_d = 32'd0;
          if (cnt_q == 2'd3) begin
            state_d = WR;
            aw_d    = 1'b1;
            w_d     = 1'b1;
          end
        end else if (idle_last) begin
          idle_d  = 32'd0;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      WR: begin
        // AW and W channels retire independently
        if (aw_q && axi.awready) aw_d = 1'b0;
        if (w_q && axi.wready) w_d = 1'b0;
        if (aw_fin && w_fin) state_d = WRESP;
      end
      WRESP: begin
        if (axi.bvalid) begin
          rep_d   = {8'h4B, 24'h0};
          rep_n_d = 3'd1;
          state_d = TX;
        end
      end
      RD: begin
        if (axi.arready) begin
          ar_d    = 1'b0;
          state_d = RRESP;
        end
      end
      RRESP: begin
        if (axi.rvalid) begin
          rep_d   = axi.rdata;
          rep_n_d = 3'd4;
          state_d = TX;
        end
      end
      TX: begin
        // reply bytes leave from the top, MSB first
        if (tx_ready) begin
          rep_d   = {rep_q[23:0], 8'h0};
          rep_n_d = rep_n_q - 3'd1;
          if (rep_n_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= 2'd0;
      idle_q  <= 32'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      ar_q    <= 1'b0;
      rep_q   <= 32'd0;
      rep_n_q <= 3'd0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      ar_q    <= ar_d;
      rep_q   <= rep_d;
      rep_n_q <= rep_n_d;
    end
  end

  assign axi.awvalid = aw_q;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = AXI_PROT;
  assign axi.wvalid  = w_q;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = {4{w_q}};
  assign axi.bready  = (state_q == WRESP);
  assign axi.arvalid = ar_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = AXI_PROT;
  assign axi.rready  = (state_q == RRESP);

  assign tx_valid = (state_q == TX);
  assign tx_data  = rep_q[31:24];
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_axi_master_bridge.sv
// Scoreboard bench for uart_axi_master_bridge.
// Drives UART frames, models an AXI slave, checks AXI and tx bytes.
module tb_uart_axi_master_bridge;
  localparam logic [31:0] TMO  = 32'd20;
  localparam logic [2:0]  PROT = 3'b101;

  logic       clk;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;

  uart_axi_master_bridge_if axi();

  uart_axi_master_bridge #(
    .RX_TIMEOUT(TMO),
    .AXI_PROT(PROT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .busy(busy),
    .axi(axi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_aw[$];
  logic [31:0] q_w[$];
  logic [31:0] q_ar[$];
  logic [7:0]  q_tx[$];

  int          aw_delay  = 0;
  int          exp_aw_hi = 1;
  bit          r_hold    = 0;
  bit          tx_stall  = 0;
  logic [31:0] rd_val    = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // AXI slave model plus output monitor
  initial begin
    bit got_aw = 0;
    bit got_w  = 0;
    bit got_ar = 0;
    bit b_pend = 0;
    bit r_pend = 0;
    bit b_seen = 0;
    int aw_cnt = 0;
    int aw_hi  = 0;
    int w_hi   = 0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'h0;
    tx_ready    = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        got_aw = 0; got_w = 0; got_ar = 0;
        b_pend = 0; r_pend = 0; b_seen = 0;
        aw_cnt = 0; aw_hi = 0; w_hi = 0;
      end else begin
        if (b_seen) begin
          chk("b2tx_lat", tx_valid, 1);
          b_seen = 0;
        end
        if (tx_valid) begin
          chk("tx_pend", q_tx.size() != 0, 1);
          if (q_tx.size() != 0) begin
            chk("tx_data", tx_data, q_tx[0]);
            if (tx_ready) void'(q_tx.pop_front());
          end
        end
        if (axi.awvalid) begin
          aw_hi++;
          chk("aw_pend", q_aw.size() != 0, 1);
          if (q_aw.size() != 0) begin
            chk("awaddr", axi.awaddr, q_aw[0]);
            if (axi.awready) begin
              void'(q_aw.pop_front());
              got_aw = 1;
            end
          end
        end
        if (axi.wvalid) begin
          w_hi++;
          chk("w_pend", q_w.size() != 0, 1);
          chk("wstrb", axi.wstrb, 4'hF);
          if (q_w.size() != 0) begin
            chk("wdata", axi.wdata, q_w[0]);
            if (axi.wready) begin
              void'(q_w.pop_front());
              got_w = 1;
            end
          end
        end
        if (axi.bvalid && axi.bready) begin
          b_pend = 0;
          b_seen = 1;
          chk("aw_hi", aw_hi, exp_aw_hi);
          chk("w_hi", w_hi, 1);
          aw_hi = 0;
          w_hi  = 0;
        end
        if (axi.arvalid) begin
          chk("ar_pend", q_ar.size() != 0, 1);
          if (q_ar.size() != 0) begin
            chk("araddr", axi.araddr, q_ar[0]);
            if (axi.arready) begin
              void'(q_ar.pop_front());
              got_ar = 1;
            end
          end
        end
        if (axi.rvalid && axi.rready) r_pend = 0;
        if (!busy) chk("rb_idle", {axi.bready, axi.rready}, 0);
      end
      @(posedge clk);
      #1;
      if (!resetn) begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        tx_ready    = 1'b0;
      end else begin
        if (axi.awvalid) aw_cnt++;
        else aw_cnt = 0;
        axi.awready = (aw_delay == 0) ||
                      (axi.awvalid && aw_cnt >= aw_delay);
        axi.wready  = 1'b1;
        axi.arready = 1'b1;
        if (got_aw && got_w) begin
          got_aw = 0;
          got_w  = 0;
          b_pend = 1;
        end
        axi.bvalid = b_pend;
        if (got_ar && !r_hold) begin
          got_ar = 0;
          r_pend = 1;
        end
        axi.rvalid = r_pend;
        axi.rdata  = rd_val;
        tx_ready   = !tx_stall;
      end
    end
  end

  task automatic send(input logic [7:0] f [9], input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = f[i];
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = !busy && q_tx.size() == 0 && q_aw.size() == 0 &&
           q_w.size() == 0 && q_ar.size() == 0;
    end
    chk("done", ok, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_txv"}, tx_valid, 0);
    chk({tag, "_aw"}, {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    chk({tag, "_br"}, {axi.bready, axi.rready}, 0);
    chk({tag, "_awaddr"}, axi.awaddr, 0);
    chk({tag, "_araddr"}, axi.araddr, 0);
    chk({tag, "_wdata"}, axi.wdata, 0);
  endtask

  initial begin
    bit seen;
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("awprot", axi.awprot, PROT);
    chk("arprot", axi.arprot, PROT);
    resetn = 1'b1;

    // basic write
    q_aw.push_back(32'h00018008);
    q_w.push_back(32'h00000041);
    q_tx.push_back(8'h4B);
    send('{8'h57, 8'h00, 8'h01, 8'h80, 8'h08,
           8'h00, 8'h00, 8'h00, 8'h41}, 9);
    chk("aw_lat", axi.awvalid, 1);
    wait_done();

    // basic read
    rd_val = 32'h000000D9;
    q_ar.push_back(32'h00018004);
    q_tx.push_back(8'h00);
    q_tx.push_back(8'h00);
    q_tx.push_back(8'h00);
    q_tx.push_back(8'hD9);
    send('{8'h52, 8'h00, 8'h01, 8'h80, 8'h04,
           8'h0, 8'h0, 8'h0, 8'h0}, 5);
    chk("ar_lat", axi.arvalid, 1);
    wait_done();

    // write with slow awready
    aw_delay  = 3;
    exp_aw_hi = 3;
    q_aw.push_back(32'h00000010);
    q_w.push_back(32'hCAFEF00D);
    q_tx.push_back(8'h4B);
    send('{8'h57, 8'h00, 8'h00, 8'h00, 8'h10,
           8'hCA, 8'hFE, 8'hF0, 8'h0D}, 9);
    wait_done();
    aw_delay  = 0;
    exp_aw_hi = 1;

    // unknown command byte
    q_tx.push_back(8'h3F);
    send('{8'h11, 8'h0, 8'h0, 8'h0, 8'h0,
           8'h0, 8'h0, 8'h0, 8'h0}, 1);
    wait_done();

    // partial frame then silence
    send('{8'h52, 8'hAA, 8'hBB, 8'h0, 8'h0,
           8'h0, 8'h0, 8'h0, 8'h0}, 3);
    repeat (TMO - 2) @(posedge clk);
    #1;
    chk("tmo_before", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("tmo_after", busy, 0);

    // read reply with tx back-pressure, stray byte in TX
    tx_stall = 1;
    rd_val   = 32'hA1B2C3D4;
    q_ar.push_back(32'h00000040);
    q_tx.push_back(8'hA1);
    q_tx.push_back(8'hB2);
    q_tx.push_back(8'hC3);
    q_tx.push_back(8'hD4);
    send('{8'h52, 8'h00, 8'h00, 8'h00, 8'h40,
           8'h0, 8'h0, 8'h0, 8'h0}, 5);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = tx_valid;
    end
    chk("tx_seen", seen, 1);
    send('{8'h57, 8'h0, 8'h0, 8'h0, 8'h0,
           8'h0, 8'h0, 8'h0, 8'h0}, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_hold", q_tx.size(), 4);
    tx_stall = 0;
    wait_done();

    // reset while waiting for rvalid
    r_hold = 1;
    q_ar.push_back(32'h00000080);
    send('{8'h52, 8'h00, 8'h00, 8'h00, 8'h80,
           8'h0, 8'h0, 8'h0, 8'h0}, 5);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = axi.rready;
    end
    chk("rresp_seen", seen, 1);
    resetn = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    r_hold = 0;

    // read after reset
    rd_val = 32'h12345678;
    q_ar.push_back(32'h00000084);
    q_tx.push_back(8'h12);
    q_tx.push_back(8'h34);
    q_tx.push_back(8'h56);
    q_tx.push_back(8'h78);
    send('{8'h52, 8'h00, 8'h00, 8'h00, 8'h84,
           8'h0, 8'h0, 8'h0, 8'h0}, 5);
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    chk("q_left", q_tx.size() + q_aw.size() +
        q_w.size() + q_ar.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
